// File: rtl/tm1638_key_event.sv
`default_nettype none
// ============================================================================
//  Module   : tm1638_key_event
//  Brief    : Debounce, press/release/toggle events and auto-repeat for the
//             eight TM1638 keys, paced by an internal 1 ms tick.
//  Revision : 1.0 - initial release
// ============================================================================
module tm1638_key_event #(
    parameter int unsigned C_FCK         = 48_000_000,
    parameter int unsigned C_DB_MS       = 20,
    parameter int unsigned C_REP_DLY_MS  = 500,
    parameter int unsigned C_REP_RATE_MS = 100,
    parameter logic [7:0]  C_TOGGLE_INIT = 8'h00
) (
    input  logic       CK_i,
    input  logic       ARST_i,
    input  logic [7:0] KEYS_i,
    input  logic       TGL_CLR_i,
    output logic [7:0] KEYS_o,
    output logic [7:0] PRESS_o,
    output logic [7:0] RELEASE_o,
    output logic [7:0] TOGGLE_o,
    output logic [7:0] REPEAT_o,
    output logic       TICK_o
);

    localparam int unsigned      c_DIV      = C_FCK / 1000;
    localparam int unsigned      c_TW       = $clog2(c_DIV);
    localparam logic [c_TW-1:0]  c_TICK_MAX = c_TW'(c_DIV - 1);
    localparam logic [c_TW-1:0]  c_TICK_ONE = c_TW'(1);
    localparam logic [7:0]       c_DB_LAST  = 8'(C_DB_MS - 1);
    localparam logic [11:0]      c_DLY      = 12'(C_REP_DLY_MS);
    localparam logic [11:0]      c_RATE     = 12'(C_REP_RATE_MS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RPT   = 2'd2
    } state_t;

    logic [c_TW-1:0] r_tick_cnt;
    logic            w_tick;
    logic [7:0]      r_keys_s;
    logic [7:0]      w_flip;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [11:0]     r_rcnt;
    logic [11:0]     w_rcnt_nxt;
    logic [11:0]     w_rcnt_inc;
    logic [2:0]      r_rep_key;
    logic [2:0]      w_rep_key_nxt;
    logic [2:0]      w_low_idx;
    logic [7:0]      r_auto;
    logic [7:0]      w_auto_nxt;

    assign w_tick = (r_tick_cnt == c_TICK_MAX);
    assign TICK_o = w_tick;

    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            r_tick_cnt <= '0;
            r_keys_s   <= 8'h00;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + c_TICK_ONE;
            r_keys_s   <= KEYS_i;
        end
    end

    // Counter counts consecutive disagreeing ticks; the flip fires on the tick
    // that would bring it to C_DB_MS, so it never stores that value.
    for (genvar k = 0; k < 8; k++) begin : g_key
        logic [7:0] r_mis;
        logic       w_mismatch;

        assign w_mismatch = (r_keys_s[k] != KEYS_o[k]);
        assign w_flip[k]  = w_tick && w_mismatch && (r_mis == c_DB_LAST);

        always_ff @(posedge CK_i or posedge ARST_i) begin
            if (ARST_i) begin
                r_mis <= 8'h00;
            end else if (w_tick) begin
                r_mis <= (w_mismatch && !w_flip[k]) ? r_mis + 8'd1 : 8'h00;
            end
        end
    end

    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            KEYS_o    <= 8'h00;
            PRESS_o   <= 8'h00;
            RELEASE_o <= 8'h00;
            TOGGLE_o  <= C_TOGGLE_INIT;
        end else begin
            KEYS_o    <= KEYS_o ^ w_flip;
            PRESS_o   <= w_flip & ~KEYS_o;
            RELEASE_o <= w_flip & KEYS_o;
            TOGGLE_o  <= TGL_CLR_i ? C_TOGGLE_INIT : (TOGGLE_o ^ (w_flip & ~KEYS_o));
        end
    end

    always_comb begin
        w_low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (PRESS_o[i]) w_low_idx = 3'(i);
        end
    end

    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            r_state   <= ST_IDLE;
            r_rcnt    <= 12'd0;
            r_rep_key <= 3'd0;
            r_auto    <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_rep_key <= w_rep_key_nxt;
            r_auto    <= w_auto_nxt;
        end
    end

    // Priority: new press retargets, then release cancels, then tick expiry.
    always_comb begin
        w_state_nxt   = r_state;
        w_rcnt_nxt    = r_rcnt;
        w_rep_key_nxt = r_rep_key;
        w_auto_nxt    = 8'h00;
        w_rcnt_inc    = r_rcnt + 12'd1;
        if (PRESS_o != 8'h00) begin
            w_rep_key_nxt = w_low_idx;
            w_rcnt_nxt    = 12'd0;
            w_state_nxt   = ST_DELAY;
        end else if (r_state != ST_IDLE) begin
            if (!KEYS_o[r_rep_key]) begin
                w_state_nxt = ST_IDLE;
                w_rcnt_nxt  = 12'd0;
            end else if (w_tick) begin
                if (w_rcnt_inc == ((r_state == ST_DELAY) ? c_DLY : c_RATE)) begin
                    w_auto_nxt  = 8'd1 << r_rep_key;
                    w_rcnt_nxt  = 12'd0;
                    w_state_nxt = ST_RPT;
                end else begin
                    w_rcnt_nxt  = w_rcnt_inc;
                end
            end
        end
    end

    assign REPEAT_o = PRESS_o | r_auto;

endmodule
`default_nettype wire
